ef_psram_arbiter: RTL and testbench
===================================

Name: ef_psram_arbiter

Overview:
- Shares one EF_PSRAM_CTRL_V2 core (start/done handshake) between two requesters: m0 (instruction fetch) and m1 (data/DMA).
- Latches the winner's request, issues a single-cycle start to the core, and waits for done.
- Returns read data and a one-cycle ack to the winner.
- Sits between the bus-side front ends and the core, in the HCLK domain.

Parameters:
- PRIO, 0, arbitration policy: 0 = round-robin; 1 = fixed priority, m0 wins.
- TIMEOUT_CYCLES, 4096, watchdog limit in WAIT. Used only with EF_PSRAM_ARB_TIMEOUT_EN; must be at most 65535.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  reset
- m0_req  in  1  request; held high with fields stable until m0_ack
- m0_wr  in  1  1 = write, 0 = read
- m0_addr  in  24  byte address
- m0_wdata  in  32  write data
- m0_size  in  3  bytes: 1, 2 or 4
- m0_ack  out  1  one-cycle completion pulse
- m0_rdata  out  32  read data, valid while m0_ack is high
- m1_req, m1_wr, m1_addr, m1_wdata, m1_size, m1_ack, m1_rdata: identical to the m0 set
- c_start  out  1  core start pulse
- c_rd_wr  out  1  to core: 1 = read
- c_addr  out  24  to core
- c_wdata  out  32  to core
- c_size  out  3  to core
- c_done  in  1  core completion
- c_rdata  in  32  core read data
- busy  out  1  high when state is not IDLE
- gnt_id  out  1  requester owning the current or last transaction

Behaviour:
- Interface decisions: clock HCLK; reset HRESETn, asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, rr_last = 1 (m0 wins the first tie).
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req is high, select the winner, latch its wr/addr/wdata/size, set gnt_id, go to ISSUE.
  - If no req is high, stay in IDLE.
- ISSUE: c_start = 1 for exactly this cycle, then go to WAIT. c_done is ignored in ISSUE.
- WAIT: on c_done, latch c_rdata into the winner's rdata register and go to RESP. Otherwise stay in WAIT.
- RESP: the winner's ack = 1 for this cycle, then go to IDLE. The loser's ack and rdata are unchanged.
- Core-side outputs:
  - c_rd_wr = ~latched wr.
  - c_addr, c_wdata and c_size are driven from the latch registers, so they are stable from ISSUE through RESP.
  - All of them are registered.
- Arbitration:
  - PRIO = 1: m0 wins whenever m0_req is high.
  - PRIO = 0: if only one requester is asking, it wins. If both are asking, the requester other than rr_last wins.
  - rr_last is updated to the winner when leaving IDLE.
- Latency:
  - req seen in IDLE at cycle N gives c_start at N+1.
  - c_done at cycle D gives ack at D+1 and IDLE at D+2.
  - A req held or re-asserted in the cycle after ack is arbitrated at D+2.
- rdata registers hold their value until the next completion for that port. Read data is captured on writes too; its value is don't-care.
- c_done outside WAIT has no effect.
- A size value other than 1/2/4 is passed through unchanged; the core defines its behaviour.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. No ack is generated. The core shares HRESETn.

Optional Feature:
- Macro: EF_PSRAM_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to WAIT and increments each WAIT cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 without c_done, go to RESP.
  - The winner's rdata is set to 32'hDEAD_BEEF and the added output mN_err (1 bit per port) = 1 with that ack.
  - mN_err = 0 on normal acks and is 0 at reset.
  - If c_done and timeout occur in the same cycle, c_done wins and err = 0.
- When not defined: no counter, no mN_err ports, WAIT is unbounded.

Test Plan:
- Single read: m0 reads 0x000100, size 4, core done after 20 cycles with c_rdata = 0x12345678 -> c_start 1 cycle after req; c_rd_wr = 1, c_addr = 0x000100; m0_ack 1 cycle after done; m0_rdata = 0x12345678; m1_ack stays 0.
- Simultaneous requests, PRIO = 0: m0 and m1 both held high for 3 transactions -> grant order m0, m1, m0; gnt_id matches each grant; each ack goes to the correct port.
- Simultaneous requests, PRIO = 1: both held high for 3 transactions -> m0 served every time; m1 served only after m0_req drops.
- Write passthrough: m1 writes 0xA5A5A5A5 to 0x7FFFFC, size 2 -> c_rd_wr = 0, c_wdata = 0xA5A5A5A5, c_size = 2; all three stable until m1_ack; stray c_done pulse in IDLE and in ISSUE ignored.
- Reset in WAIT: HRESETn low for 2 cycles mid-read -> busy = 0, no ack, c_start = 0; next m1 request is served normally; first tie afterwards goes to m0.
- Timeout (EF_PSRAM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 16): no c_done -> m0_ack with m0_err = 1, m0_rdata = 0xDEADBEEF, 16 cycles after WAIT entry; done coinciding with expiry -> err = 0 and rdata taken from c_rdata.

Source files
------------

// File: rtl/ef_psram_arbiter.sv
// ef_psram_arbiter: shares one EF_PSRAM_CTRL_V2 core between an instruction-fetch (m0) and a data/DMA (m1) requester.
// Define EF_PSRAM_ARB_TIMEOUT_EN to add a WAIT watchdog and the m0_err/m1_err outputs.
module ef_psram_arbiter #(
  parameter int PRIO           = 0,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [23:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [2:0]  m0_size,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [23:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [2:0]  m1_size,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
`ifdef EF_PSRAM_ARB_TIMEOUT_EN
  output logic        m0_err,
  output logic        m1_err,
`endif
  output logic        c_start,
  output logic        c_rd_wr,
  output logic [23:0] c_addr,
  output logic [31:0] c_wdata,
  output logic [2:0]  c_size,
  input  logic        c_done,
  input  logic [31:0] c_rdata,
  output logic        busy,
  output logic        gnt_id
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        win;
  logic        rr_last;
  logic        grant;
  logic        done_take;
  logic        wait_end;
  logic [31:0] resp_data;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("ef_psram_arbiter: TIMEOUT_CYCLES must be in 1..65535");
  end

  assign grant     = (state == IDLE) && (m0_req || m1_req);
  assign done_take = (state == WAIT) && c_done;

  // Winner select: only meaningful while grant is high.
  always_comb begin
    win = 1'b0;
    if (PRIO == 1) begin
      win = ~m0_req;
    end else if (m0_req && m1_req) begin
      win = ~rr_last;
    end else begin
      win = m1_req;
    end
  end

`ifdef EF_PSRAM_ARB_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wait_cnt;
  logic        expire;
  logic        err_flag;

  assign expire    = (state == WAIT) && (wait_cnt == TO_LAST);
  assign wait_end  = done_take || expire;
  assign resp_data = done_take ? c_rdata : 32'hDEAD_BEEF;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      wait_cnt <= '0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // A c_done in the expiry cycle still counts as a normal completion.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      err_flag <= 1'b0;
    end else if (wait_end) begin
      err_flag <= ~done_take;
    end
  end

  assign m0_err = m0_ack && err_flag;
  assign m1_err = m1_ack && err_flag;
`else
  assign wait_end  = done_take;
  assign resp_data = c_rdata;
`endif

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (wait_end) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    c_start = 1'b0;
    busy    = 1'b1;
    m0_ack  = 1'b0;
    m1_ack  = 1'b0;
    case (state)
      IDLE:  busy = 1'b0;
      ISSUE: c_start = 1'b1;
      RESP: begin
        m0_ack = ~gnt_id;
        m1_ack = gnt_id;
      end
      default: ;
    endcase
  end

  // Winner's fields are frozen here for the whole ISSUE..RESP window.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      gnt_id  <= 1'b0;
      rr_last <= 1'b1;
      c_rd_wr <= 1'b0;
      c_addr  <= '0;
      c_wdata <= '0;
      c_size  <= '0;
    end else if (grant) begin
      gnt_id  <= win;
      rr_last <= win;
      c_rd_wr <= win ? ~m1_wr    : ~m0_wr;
      c_addr  <= win ? m1_addr  : m0_addr;
      c_wdata <= win ? m1_wdata : m0_wdata;
      c_size  <= win ? m1_size  : m0_size;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else if (wait_end) begin
      if (gnt_id) begin
        m1_rdata <= resp_data;
      end else begin
        m0_rdata <= resp_data;
      end
    end
  end

endmodule

// File: tb/tb_ef_psram_arbiter.sv
// Bench for ef_psram_arbiter: a round-robin and a fixed-priority instance, each checked against a transaction-level model.
module tb_ef_psram_arbiter;

`ifdef EF_PSRAM_ARB_TIMEOUT_EN
  localparam int TO   = 16;
  localparam int LONG = 12;
`else
  localparam int TO   = 4096;
  localparam int LONG = 20;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req   [2][2];
  logic        wr    [2][2];
  logic [23:0] addr  [2][2];
  logic [31:0] wdata [2][2];
  logic [2:0]  size  [2][2];
  logic        ack   [2][2];
  logic [31:0] rdata [2][2];
`ifdef EF_PSRAM_ARB_TIMEOUT_EN
  logic        err   [2][2];
`endif
  logic        c_start [2];
  logic        c_rd_wr [2];
  logic [23:0] c_addr  [2];
  logic [31:0] c_wdata [2];
  logic [2:0]  c_size  [2];
  logic        c_done  [2];
  logic [31:0] c_rdata [2];
  logic        busy    [2];
  logic        gnt_id  [2];

  int nvec = 0;
  int nerr = 0;

  // Model state: which port was served last, and what each port's rdata should show.
  int          last_served [2];
  logic [31:0] exp_rd [2][2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ef_psram_arbiter #(.PRIO(g), .TIMEOUT_CYCLES(TO)) u_dut (
      .HCLK(clk), .HRESETn(rst_n),
      .m0_req(req[g][0]), .m0_wr(wr[g][0]), .m0_addr(addr[g][0]), .m0_wdata(wdata[g][0]),
      .m0_size(size[g][0]), .m0_ack(ack[g][0]), .m0_rdata(rdata[g][0]),
      .m1_req(req[g][1]), .m1_wr(wr[g][1]), .m1_addr(addr[g][1]), .m1_wdata(wdata[g][1]),
      .m1_size(size[g][1]), .m1_ack(ack[g][1]), .m1_rdata(rdata[g][1]),
`ifdef EF_PSRAM_ARB_TIMEOUT_EN
      .m0_err(err[g][0]), .m1_err(err[g][1]),
`endif
      .c_start(c_start[g]), .c_rd_wr(c_rd_wr[g]), .c_addr(c_addr[g]), .c_wdata(c_wdata[g]),
      .c_size(c_size[g]), .c_done(c_done[g]), .c_rdata(c_rdata[g]),
      .busy(busy[g]), .gnt_id(gnt_id[g])
    );
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [130:0] all_outs(input int d);
    logic [130:0] o;
    o = {2'b00, c_start[d], busy[d], gnt_id[d], ack[d][0], ack[d][1], c_rd_wr[d],
         c_addr[d], c_wdata[d], c_size[d], rdata[d][0], rdata[d][1]};
`ifdef EF_PSRAM_ARB_TIMEOUT_EN
    o[130:129] = {err[d][0], err[d][1]};
`endif
    return o;
  endfunction

  function automatic logic [2:0] rand_size();
    case ($urandom_range(0, 7))
      0, 1:    return 3'd1;
      2, 3:    return 3'd2;
      4, 5, 6: return 3'd4;
      default: return 3'($urandom_range(0, 7));
    endcase
  endfunction

  // Spec rule: fixed priority favours m0; round-robin favours the port not served last.
  function automatic int pick(input int d);
    if (req[d][0] && req[d][1]) return (d == 1) ? 0 : 1 - last_served[d];
    return req[d][0] ? 0 : 1;
  endfunction

  task automatic new_req(input int d, input int p, input logic w, input logic [23:0] a,
                         input logic [31:0] wd, input logic [2:0] s);
    req[d][p] = 1'b1; wr[d][p] = w; addr[d][p] = a; wdata[d][p] = wd; size[d][p] = s;
  endtask

  task automatic new_rand_req(input int d, input int p);
    new_req(d, p, 1'($urandom), 24'($urandom), $urandom, rand_size());
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      last_served[d] = 1;
      exp_rd[d][0] = '0;
      exp_rd[d][1] = '0;
    end
  endtask

  // One full transaction from an IDLE cycle with requests pending, through ack, back to IDLE.
  task automatic txn(input int d, input int wn, input bit nodone, input bit stray,
                     input bit keep0, input bit keep1, input logic [31:0] v);
    int          w;
    bit          keep [2];
    logic [59:0] core_exp;
    logic [31:0] erd;
    keep[0] = keep0;
    keep[1] = keep1;
    w = pick(d);
    core_exp = {~wr[d][w], addr[d][w], wdata[d][w], size[d][w]};
    last_served[d] = w;
    step();
    nvec++;
    if ({c_start[d], busy[d], ack[d][0], ack[d][1]} !== 4'b1100) begin
      nerr++; $display("FAIL issue_ctl dut%0d: got %b want 1100", d, {c_start[d], busy[d], ack[d][0], ack[d][1]});
    end
    nvec++;
    if (gnt_id[d] !== 1'(w)) begin
      nerr++; $display("FAIL issue_gnt dut%0d: got %b want %0d", d, gnt_id[d], w);
    end
    nvec++;
    if ({c_rd_wr[d], c_addr[d], c_wdata[d], c_size[d]} !== core_exp) begin
      nerr++; $display("FAIL issue_core dut%0d: got %h want %h", d, {c_rd_wr[d], c_addr[d], c_wdata[d], c_size[d]}, core_exp);
    end
    if (stray) begin
      c_done[d] = 1'b1;
      c_rdata[d] = $urandom;
    end
    for (int i = 1; i <= wn; i++) begin
      step();
      c_done[d] = 1'b0;
      nvec++;
      if ({c_start[d], busy[d], ack[d][0], ack[d][1]} !== 4'b0100) begin
        nerr++; $display("FAIL wait_ctl dut%0d cyc%0d: got %b want 0100", d, i, {c_start[d], busy[d], ack[d][0], ack[d][1]});
      end
      nvec++;
      if ({c_rd_wr[d], c_addr[d], c_wdata[d], c_size[d]} !== core_exp) begin
        nerr++; $display("FAIL wait_core dut%0d: got %h want %h", d, {c_rd_wr[d], c_addr[d], c_wdata[d], c_size[d]}, core_exp);
      end
      if (i == wn && !nodone) begin
        c_done[d] = 1'b1;
        c_rdata[d] = v;
      end
    end
    step();
    c_done[d] = 1'b0;
    erd = nodone ? 32'hDEAD_BEEF : v;
    exp_rd[d][w] = erd;
    nvec++;
    if ({c_start[d], busy[d], ack[d][w], ack[d][1-w]} !== 4'b0110) begin
      nerr++; $display("FAIL resp_ack dut%0d m%0d: got %b want 0110", d, w, {c_start[d], busy[d], ack[d][w], ack[d][1-w]});
    end
    nvec++;
    if ({rdata[d][0], rdata[d][1]} !== {exp_rd[d][0], exp_rd[d][1]}) begin
      nerr++; $display("FAIL resp_rdata dut%0d: got %h want %h", d, {rdata[d][0], rdata[d][1]}, {exp_rd[d][0], exp_rd[d][1]});
    end
    nvec++;
    if ({c_rd_wr[d], c_addr[d], c_wdata[d], c_size[d]} !== core_exp) begin
      nerr++; $display("FAIL resp_core dut%0d: got %h want %h", d, {c_rd_wr[d], c_addr[d], c_wdata[d], c_size[d]}, core_exp);
    end
`ifdef EF_PSRAM_ARB_TIMEOUT_EN
    nvec++;
    if ({err[d][w], err[d][1-w]} !== {nodone, 1'b0}) begin
      nerr++; $display("FAIL resp_err dut%0d m%0d: got %b want %b", d, w, {err[d][w], err[d][1-w]}, {nodone, 1'b0});
    end
`endif
    if (keep[w]) new_rand_req(d, w);
    else req[d][w] = 1'b0;
    step();
    nvec++;
    if ({c_start[d], busy[d], ack[d][0], ack[d][1], gnt_id[d]} !== {4'b0000, 1'(w)}) begin
      nerr++; $display("FAIL idle_ctl dut%0d: got %b want %b", d, {c_start[d], busy[d], ack[d][0], ack[d][1], gnt_id[d]}, {4'b0000, 1'(w)});
    end
    nvec++;
    if ({rdata[d][0], rdata[d][1]} !== {exp_rd[d][0], exp_rd[d][1]}) begin
      nerr++; $display("FAIL idle_rdata dut%0d: got %h want %h", d, {rdata[d][0], rdata[d][1]}, {exp_rd[d][0], exp_rd[d][1]});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      c_done[d] = 1'b0;
      c_rdata[d] = '0;
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0; wr[d][p] = 1'b0; addr[d][p] = '0; wdata[d][p] = '0; size[d][p] = '0;
      end
    end
    model_reset();
    repeat (3) step();
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if (all_outs(d) !== '0) begin
        nerr++; $display("FAIL reset_outs dut%0d: got %h want 0", d, all_outs(d));
      end
    end
    rst_n = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      nvec++;
      if ({c_start[d], busy[d], ack[d][0], ack[d][1]} !== 4'b0000) begin
        nerr++; $display("FAIL post_reset_idle dut%0d: got %b want 0000", d, {c_start[d], busy[d], ack[d][0], ack[d][1]});
      end
    end
  endtask

  task automatic test_rr();
    new_rand_req(0, 0);
    new_rand_req(0, 1);
    txn(0, 3, 0, 0, 1, 1, $urandom);
    txn(0, 2, 0, 0, 1, 1, $urandom);
    txn(0, 4, 0, 0, 0, 1, $urandom);
    txn(0, 1, 0, 0, 0, 0, $urandom);
  endtask

  task automatic test_single_read();
    new_req(0, 0, 1'b0, 24'h000100, 32'h0, 3'd4);
    txn(0, LONG, 0, 0, 0, 0, 32'h1234_5678);
  endtask

  task automatic test_write();
    c_done[0] = 1'b1;
    c_rdata[0] = 32'h0BAD_0BAD;
    step();
    c_done[0] = 1'b0;
    nvec++;
    if ({busy[0], ack[0][0], ack[0][1], rdata[0][0], rdata[0][1]} !== {3'b000, exp_rd[0][0], exp_rd[0][1]}) begin
      nerr++; $display("FAIL stray_idle_done: got %h want %h", {busy[0], ack[0][0], ack[0][1], rdata[0][0], rdata[0][1]},
                       {3'b000, exp_rd[0][0], exp_rd[0][1]});
    end
    new_req(0, 1, 1'b1, 24'h7FFFFC, 32'hA5A5_A5A5, 3'd2);
    txn(0, 5, 0, 1, 0, 0, $urandom);
  endtask

  task automatic test_prio();
    new_rand_req(1, 0);
    new_rand_req(1, 1);
    txn(1, 2, 0, 0, 1, 1, $urandom);
    txn(1, 3, 0, 0, 1, 1, $urandom);
    txn(1, 1, 0, 0, 0, 1, $urandom);
    txn(1, 2, 0, 0, 0, 0, $urandom);
  endtask

  task automatic test_reset_wait();
    new_req(0, 0, 1'b0, 24'h000200, 32'h0, 3'd4);
    repeat (4) step();
    rst_n = 1'b0;
    req[0][0] = 1'b0;
    #1;
    nvec++;
    if (all_outs(0) !== '0) begin
      nerr++; $display("FAIL reset_in_wait: got %h want 0", all_outs(0));
    end
    for (int i = 0; i < 2; i++) begin
      step();
      nvec++;
      if ({c_start[0], busy[0], ack[0][0], ack[0][1]} !== 4'b0000) begin
        nerr++; $display("FAIL reset_hold cyc%0d: got %b want 0000", i, {c_start[0], busy[0], ack[0][0], ack[0][1]});
      end
    end
    rst_n = 1'b1;
    model_reset();
    step();
    nvec++;
    if ({c_start[0], busy[0], ack[0][0], ack[0][1]} !== 4'b0000) begin
      nerr++; $display("FAIL reset_release: got %b want 0000", {c_start[0], busy[0], ack[0][0], ack[0][1]});
    end
    new_rand_req(0, 1);
    txn(0, 3, 0, 0, 0, 0, $urandom);
    new_rand_req(0, 0);
    new_rand_req(0, 1);
    txn(0, 2, 0, 0, 0, 0, $urandom);
    txn(0, 2, 0, 0, 0, 0, $urandom);
  endtask

`ifdef EF_PSRAM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    new_req(0, 0, 1'b0, 24'h000400, 32'h0, 3'd4);
    txn(0, TO, 1, 0, 0, 0, $urandom);
    new_req(0, 0, 1'b0, 24'h000404, 32'h0, 3'd4);
    txn(0, TO, 0, 0, 0, 0, 32'hCAFE_F00D);
  endtask
`endif

  task automatic test_random(input int d);
    for (int it = 0; it < 30; it++) begin
      if (!req[d][0] && $urandom_range(0, 1) == 1) new_rand_req(d, 0);
      if (!req[d][1] && $urandom_range(0, 1) == 1) new_rand_req(d, 1);
      if (!req[d][0] && !req[d][1]) new_rand_req(d, int'($urandom_range(0, 1)));
      txn(d, int'($urandom_range(1, 12)), 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom);
    end
    for (int k = 0; k < 2 && (req[d][0] || req[d][1]); k++) begin
      txn(d, 2, 0, 0, 0, 0, $urandom);
    end
  endtask

  initial begin
    test_reset();
    test_rr();
    test_single_read();
    test_write();
    test_prio();
    test_reset_wait();
`ifdef EF_PSRAM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random(0);
    test_random(1);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
